// File: rtl/fp_from_int_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_from_int_pkg
// Purpose  : Shared fp helpers: exponent bias, min/max, clog2, packed IEEE754 type.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef FP_IEEE754_MACRO
`define FP_IEEE754_MACRO
`define IEEE754(NX, NM) struct packed { logic sign; logic [(NX)-1:0] exp; logic [(NM)-1:0] mant; }
`endif

package fp_from_int_pkg;

    function automatic int EXP_OFFSET(input int nx);
        return (1 << (nx - 1)) - 1;
    endfunction

    function automatic int MIN(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int MAX(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int CLOG2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_rne
// Purpose  : Round a normalised integer magnitude to packed IEEE754, nearest-even.
// Revision : 1.0 - initial release
// ============================================================================

module fp_round_rne
    import fp_from_int_pkg::*;
#(
    parameter int NI = 32,
    parameter int NX = 8,
    parameter int NM = 23,
    parameter int NE = 6
) (
    input  logic [NI-1:0]    mag,
    input  logic [NE-1:0]    exp_unb,
    input  logic             sign,
    output logic [NX+NM:0]   data,
    output logic             inexact
);

    localparam int FW = NI - 1;
    localparam int EW = MAX(NE, NX + 2);
    localparam logic signed [EW-1:0] c_bias    = EW'(EXP_OFFSET(NX));
    localparam logic signed [EW-1:0] c_exp_max = EW'((1 << NX) - 1);

    typedef `IEEE754(NX, NM) ieee_t;

    // Fraction bits below the hidden one, padded so guard/sticky vanish when NI-1 <= NM.
    logic [FW+NM+1:0]       w_ext;
    logic [NM-1:0]          w_mant;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_round_up;
    logic [NM:0]            w_mant_inc;
    logic signed [EW-1:0]   w_biased;
    logic                   w_ovf;
    logic                   w_zero;
    ieee_t                  w_res;

    assign w_ext      = {mag[NI-2:0], {(NM + 2){1'b0}}};
    assign w_mant     = w_ext[FW+NM+1 -: NM];
    assign w_guard    = w_ext[FW+1];
    assign w_sticky   = |w_ext[FW:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_inc = {1'b0, w_mant} + {{NM{1'b0}}, w_round_up};
    assign w_biased   = EW'($signed(exp_unb)) + $signed(EW'(w_mant_inc[NM])) + c_bias;
    assign w_ovf      = (w_biased >= c_exp_max);
    assign w_zero     = ~mag[NI-1];

    always_comb begin
        w_res = '0;
        if (!w_zero) begin
            w_res.sign = sign;
            if (w_ovf) begin
                w_res.exp  = '1;
                w_res.mant = '0;
            end else begin
                w_res.exp  = w_biased[NX-1:0];
                w_res.mant = w_mant_inc[NM-1:0];
            end
        end
    end

    assign data    = w_res;
    assign inexact = ~w_zero & (w_guard | w_sticky | w_ovf);

endmodule

`default_nettype wire

// File: rtl/fp_from_int.sv
`default_nettype none
// ============================================================================
// Module   : fp_from_int
// Purpose  : Iterative integer to IEEE754 converter with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================

module fp_from_int
    import fp_from_int_pkg::*;
#(
    parameter int NI     = 32,
    parameter bit SIGNED = 1'b1,
    parameter int NX     = 8,
    parameter int NM     = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NI-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NX+NM:0]   out_data,
    output logic             out_inexact
);

    localparam int NE = CLOG2(NI) + 1;
    localparam logic [NE-1:0] c_exp_top = NE'(NI - 1);

    typedef `IEEE754(NX, NM) ieee_t;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [NI-1:0]      r_mag;
    logic [NE-1:0]      r_exp;
    logic               r_sign;
    ieee_t              r_result;
    logic               r_inexact;
    logic               r_out_valid;
    logic               r_in_ready;

    logic               w_sign;
    logic [NI-1:0]      w_mag;
    logic [NX+NM:0]     w_rnd_data;
    logic               w_rnd_inexact;

    // Negating the most negative value wraps to 2^(NI-1), which is the exact magnitude.
    assign w_sign = SIGNED & in_data[NI-1];
    assign w_mag  = w_sign ? (~in_data + NI'(1)) : in_data;

    fp_round_rne #(
        .NI (NI),
        .NX (NX),
        .NM (NM),
        .NE (NE)
    ) u_round (
        .mag     (r_mag),
        .exp_unb (r_exp),
        .sign    (r_sign),
        .data    (w_rnd_data),
        .inexact (w_rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mag       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_result    <= '0;
            r_inexact   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= w_sign;
                        r_mag      <= w_mag;
                        r_exp      <= c_exp_top;
                        if (w_mag == '0) begin
                            r_result    <= '0;
                            r_inexact   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (r_mag[NI-1]) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - NE'(1);
                    end
                end
                S_ROUND: begin
                    r_result    <= w_rnd_data;
                    r_inexact   <= w_rnd_inexact;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_result;
    assign out_inexact = r_inexact;

endmodule

`default_nettype wire

// File: tb/tb_fp_from_int.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_from_int
// Purpose  : Directed self-checking bench for fp_from_int (three configurations).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fp_from_int;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2:0]     r_in_valid;
    logic [2:0]     r_out_ready;
    logic [31:0]    r_in_data [3];
    logic [2:0]     w_in_ready;
    logic [2:0]     w_out_valid;
    logic [2:0]     w_inexact;
    logic [31:0]    w_od0;
    logic [15:0]    w_od1;
    logic [31:0]    w_od2;
    logic [31:0]    w_od [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign w_od[0] = w_od0;
    assign w_od[1] = {16'h0000, w_od1};
    assign w_od[2] = w_od2;

    // Instance 0: default single precision, signed
    fp_from_int #(.NI(32), .SIGNED(1'b1), .NX(8), .NM(23)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(r_in_valid[0]), .in_ready(w_in_ready[0]),
        .in_data(r_in_data[0]), .out_valid(w_out_valid[0]), .out_ready(r_out_ready[0]),
        .out_data(w_od0), .out_inexact(w_inexact[0]));

    // Instance 1: half precision, signed
    fp_from_int #(.NI(32), .SIGNED(1'b1), .NX(5), .NM(10)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(r_in_valid[1]), .in_ready(w_in_ready[1]),
        .in_data(r_in_data[1]), .out_valid(w_out_valid[1]), .out_ready(r_out_ready[1]),
        .out_data(w_od1), .out_inexact(w_inexact[1]));

    // Instance 2: single precision, unsigned
    fp_from_int #(.NI(32), .SIGNED(1'b0), .NX(8), .NM(23)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(r_in_valid[2]), .in_ready(w_in_ready[2]),
        .in_data(r_in_data[2]), .out_valid(w_out_valid[2]), .out_ready(r_out_ready[2]),
        .out_data(w_od2), .out_inexact(w_inexact[2]));

    task automatic convert(input int k, input logic [31:0] d, input bit release_out,
                           output logic [31:0] q, output logic x, output int lat);
        int n;
        n = 0;
        while (w_in_ready[k] !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (w_in_ready[k] !== 1'b1) begin
            bad++; total++;
            $display("FAIL accept_timeout inst=%0d in_ready=%b want=1", k, w_in_ready[k]);
        end
        r_in_data[k]  = d;
        r_in_valid[k] = 1'b1;
        @(posedge clk); #1;
        r_in_valid[k] = 1'b0;
        lat = 1;
        while (w_out_valid[k] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (w_out_valid[k] !== 1'b1) begin
            bad++; total++;
            $display("FAIL result_timeout inst=%0d out_valid=%b want=1", k, w_out_valid[k]);
        end
        q = w_od[k];
        x = w_inexact[k];
        if (release_out) begin
            r_out_ready[k] = 1'b1;
            @(posedge clk); #1;
            r_out_ready[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (w_out_valid !== 3'b000 || w_in_ready !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags out_valid=%b in_ready=%b want=000/000", w_out_valid, w_in_ready);
        end
        total++;
        if (w_od0 !== 32'h0 || w_inexact !== 3'b000) begin
            bad++;
            $display("FAIL reset_data got=%h/%b want=00000000/000", w_od0, w_inexact);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (w_in_ready !== 3'b111) begin
            bad++;
            $display("FAIL reset_release in_ready=%b want=111", w_in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] q; logic x; int lat;
        convert(0, 32'd1, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h3F800000 || x !== 1'b0) begin
            bad++; $display("FAIL one got=%h/%b want=3f800000/0", q, x);
        end
        total++;
        if (lat !== 34) begin
            bad++; $display("FAIL one_latency got=%0d want=34", lat);
        end
        convert(0, 32'hFFFFFFFF, 1'b1, q, x, lat);
        total++;
        if (q !== 32'hBF800000 || x !== 1'b0) begin
            bad++; $display("FAIL minus_one got=%h/%b want=bf800000/0", q, x);
        end
        convert(0, 32'd0, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h0 || x !== 1'b0 || lat !== 1) begin
            bad++; $display("FAIL zero got=%h/%b lat=%0d want=00000000/0 lat=1", q, x, lat);
        end
        convert(0, 32'd5, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h40A00000 || x !== 1'b0) begin
            bad++; $display("FAIL five got=%h/%b want=40a00000/0", q, x);
        end
    endtask

    task automatic test_extremes();
        logic [31:0] q; logic x; int lat;
        convert(0, 32'h80000000, 1'b1, q, x, lat);
        total++;
        if (q !== 32'hCF000000 || x !== 1'b0 || lat !== 3) begin
            bad++; $display("FAIL most_negative got=%h/%b lat=%0d want=cf000000/0 lat=3", q, x, lat);
        end
        convert(0, 32'h7FFFFFFF, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h4F000000 || x !== 1'b1) begin
            bad++; $display("FAIL most_positive got=%h/%b want=4f000000/1", q, x);
        end
        convert(2, 32'hFFFFFFFF, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h4F800000 || x !== 1'b1) begin
            bad++; $display("FAIL unsigned_max got=%h/%b want=4f800000/1", q, x);
        end
    endtask

    task automatic test_ties();
        logic [31:0] q; logic x; int lat;
        convert(0, 32'd16777217, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h4B800000 || x !== 1'b1) begin
            bad++; $display("FAIL tie_down got=%h/%b want=4b800000/1", q, x);
        end
        convert(0, 32'd16777219, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h4B800002 || x !== 1'b1) begin
            bad++; $display("FAIL tie_up got=%h/%b want=4b800002/1", q, x);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] q; logic x; int lat;
        convert(1, 32'd65520, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h00007C00 || x !== 1'b1) begin
            bad++; $display("FAIL ovf_tie got=%h/%b want=00007c00/1", q, x);
        end
        convert(1, 32'hFFFE7960, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h0000FC00 || x !== 1'b1) begin
            bad++; $display("FAIL ovf_negative got=%h/%b want=0000fc00/1", q, x);
        end
        convert(1, 32'd3, 1'b1, q, x, lat);
        total++;
        if (q !== 32'h00004200 || x !== 1'b0) begin
            bad++; $display("FAIL half_three got=%h/%b want=00004200/0", q, x);
        end
    endtask

    task automatic test_hold();
        logic [31:0] q; logic x; int lat;
        convert(0, 32'd5, 1'b0, q, x, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (w_od0 !== q || w_out_valid[0] !== 1'b1 || w_in_ready[0] !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d data=%h valid=%b ready=%b want=%h/1/0",
                         i, w_od0, w_out_valid[0], w_in_ready[0], q);
            end
        end
        r_out_ready[0] = 1'b1;
        @(posedge clk); #1;
        r_out_ready[0] = 1'b0;
        total++;
        if (w_in_ready[0] !== 1'b1 || w_out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL hold_release ready=%b valid=%b want=1/0", w_in_ready[0], w_out_valid[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        r_out_ready[0] = 1'b1;
        r_in_data[0]   = 32'd3;
        r_in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        r_in_data[0] = 32'd100;
        n = 0;
        while (w_out_valid[0] !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (w_od0 !== 32'h40400000 || w_out_valid[0] !== 1'b1) begin
            bad++; $display("FAIL b2b_first got=%h valid=%b want=40400000/1", w_od0, w_out_valid[0]);
        end
        @(posedge clk); #1;
        total++;
        if (w_in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL b2b_ready got=%b want=1", w_in_ready[0]);
        end
        @(posedge clk); #1;
        r_in_valid[0] = 1'b0;
        total++;
        if (w_in_ready[0] !== 1'b0) begin
            bad++; $display("FAIL b2b_accept in_ready=%b want=0", w_in_ready[0]);
        end
        n = 1;
        while (w_out_valid[0] !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (w_od0 !== 32'h42C80000 || n !== 28) begin
            bad++; $display("FAIL b2b_second got=%h lat=%0d want=42c80000 lat=28", w_od0, n);
        end
        @(posedge clk); #1;
        r_out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        r_in_data[0]  = 32'd1;
        r_in_valid[0] = 1'b1;
        @(posedge clk); #1;
        r_in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (w_in_ready[0] !== 1'b0 || w_out_valid[0] !== 1'b0) begin
            bad++; $display("FAIL midreset_hold ready=%b valid=%b want=0/0", w_in_ready[0], w_out_valid[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (w_in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL midreset_ready got=%b want=1", w_in_ready[0]);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (w_out_valid[0] === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL midreset_output out_valid_seen=%b want=0", seen);
        end
    endtask

    initial begin
        r_in_valid  = 3'b000;
        r_out_ready = 3'b000;
        for (int i = 0; i < 3; i++) r_in_data[i] = 32'h0;
        test_reset();
        test_basic();
        test_extremes();
        test_ties();
        test_overflow();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_from_int.md
# fp_from_int

Multi-cycle converter from a two's-complement or unsigned integer to a packed IEEE754 value. It uses the same `NX`/`NM` exponent/mantissa parametrisation as the rest of the fp library. It is the integer-to-float entry point feeding fp datapaths, and the counterpart to the fp-side format converters. Normalisation is iterative, one bit per cycle, and rounding is round-to-nearest-even, with a valid/ready handshake on both sides.

## Interface
- `NI`, 32, integer input width (≥ 2)
- `SIGNED`, 1, 1: `in_data` is two's complement; 0: unsigned
- `NX`, 8, output exponent width
- `NM`, 23, output mantissa width; output width is `NX+NM+1`
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  input word present
- `in_ready`  out  1  converter idle, will accept
- `in_data`  in  `NI`  integer operand
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  `NX+NM+1`  packed result {sign, exp, mant}
- `out_inexact`  out  1  result differs from the exact value (rounded or overflowed)

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture:
    - sign = `SIGNED & in_data[NI-1]`.
    - mag = sign ? −`in_data` : `in_data`, as an NI-bit unsigned value. The most negative input yields 2^(NI-1) exactly.
    - e = NI−1.
  - mag==0: go to DONE with `out_data`=0 (+0, sign cleared) and inexact=0.
  - Otherwise go to NORM.
- NORM, each cycle:
  - If mag[NI-1]=1, go to ROUND.
  - Else mag <<= 1 and e −= 1.
- ROUND, one cycle:
  - Mantissa candidate = mag[NI-2 -: NM], zero-filled on the right when NI−1 < NM.
  - guard = next lower bit; sticky = OR of all remaining bits. Both are 0 when NI−1 ≤ NM.
  - Round up iff guard && (sticky || mant LSB).
  - Mantissa carry-out: mant=0, e+=1.
  - Biased exponent = e + EXP_OFFSET(NX), where the bias is 2^(NX−1)−1.
  - If biased ≥ 2^NX−1, the result is ±infinity (exp all ones, mant 0).
  - inexact = guard|sticky|overflow.
  - Register the result, then go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_data` and `out_inexact` are held stable until `out_ready`. Then go to IDLE.
- No subnormal outputs are possible: the integer magnitude is ≥ 1.
- `in_ready` is 0 outside IDLE. There is no overlap between conversions; the minimum spacing between accepted inputs is one bubble cycle.
- Reset mid-operation: the in-flight conversion is dropped and no output is produced.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`=0, `out_data`=0, `out_inexact`=0.
  - `in_ready`=0 while `rst` is asserted, and 1 from the first cycle after deassertion.
- Latency, with acceptance at cycle 0 and lz = leading zeros of mag:
  - NORM occupies cycles 1..lz+1.
  - ROUND occupies cycle lz+2.
  - `out_valid` rises at cycle lz+3.
  - Bounds: min 3 (lz=0), max NI+2 (mag=1).
  - Zero input: `out_valid` at cycle 1.
- Output handshake completes on the cycle `out_valid && out_ready`. `in_ready` is 1 on the following cycle.
- All outputs are registered. There is no combinational path from `in_*` to `out_*`.

## Structure
- Shared fp package:
  - EXP_OFFSET(nx) and MIN (existing).
  - A CLOG2 helper for the exponent counter width, which is CLOG2(NI)+1 signed, widened to NX+2 for the bias add and overflow check.
  - The IEEE754(NX, NM) packed typedef macro, used for `out_data`.
- State enum is local to the module.
- One combinational sub-module, `fp_round_rne`:
  - Inputs: normalised magnitude, unbiased exponent, sign.
  - Outputs: packed value and inexact.
  - Reused later by the fp narrowing converter.

## Test plan
Defaults unless stated: NI=32, SIGNED=1, NX=8, NM=23.
- Basic values:
  - 1 → 0x3F800000, inexact=0, `out_valid` at cycle 34.
  - −1 → 0xBF800000.
  - 0 → 0x00000000 at cycle 1.
- Extreme inputs:
  - 0x80000000 → 0xCF000000, exact, latency 3.
  - 0x7FFFFFFF → 0x4F000000, inexact=1 (mantissa carry-out).
- Ties, rounded to even:
  - 16777217 → 0x4B800000, inexact=1 (rounds down).
  - 16777219 → 0x4B800002, inexact=1 (rounds up).
- Overflow with NX=5, NM=10:
  - 65520 → 0x7C00, inexact=1 (tie to even rounds to 65536, i.e. infinity).
  - −100000 → 0xFC00.
- SIGNED=0: 0xFFFFFFFF → 0x4F800000, inexact=1.
- Handshake:
  - Hold `out_ready`=0 for 5 cycles: `out_data` stays stable and `in_ready` stays 0.
  - Back-to-back inputs: second input accepted exactly one cycle after the output handshake.
  - Assert `rst` during NORM: `out_valid` never rises, and `in_ready`=1 on the cycle after `rst` falls.
